// File: rtl/register_pkg.sv
// register_pkg: mode encodings shared by universal_register and its users
package register_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;
endpackage

// File: rtl/universal_register.sv
// universal_register: WIDTH-bit hold/load/shift/rotate/inc/dec register; ports clk, reset, mode, in_data, ser_in -> out_data, carry, zero, ser_out_msb, ser_out_lsb
module universal_register
  import register_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out_data,
  output logic             carry,
  output logic             zero,
  output logic             ser_out_msb,
  output logic             ser_out_lsb
);
  logic [WIDTH:0] nxt;
  always_comb begin
    nxt = {carry, out_data};
    case (mode)
      MODE_LOAD: nxt = {1'b0, in_data};
      MODE_SHL:  nxt = {out_data, ser_in};
      MODE_SHR:  nxt = {out_data[0], ser_in, out_data[WIDTH-1:1]};
      MODE_ROL:  nxt = {out_data, out_data[WIDTH-1]};
      MODE_ROR:  nxt = {out_data[0], out_data[0], out_data[WIDTH-1:1]};
      MODE_INC:  nxt = {1'b0, out_data} + (WIDTH+1)'(1);
      MODE_DEC:  nxt = {1'b0, out_data} - (WIDTH+1)'(1);
      default:   nxt = {carry, out_data};
    endcase
  end
  always_ff @(posedge clk)
    if (reset) {carry, out_data} <= {1'b0, RESET_VALUE};
    else {carry, out_data} <= nxt;
  assign zero = out_data == '0;
  assign ser_out_msb = out_data[WIDTH-1];
  assign ser_out_lsb = out_data[0];
endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register: directed vectors checked against a behavioural model every cycle plus literal expectations
module tb_universal_register;
  import register_pkg::*;
  logic clk = 0, reset, ser_in;
  logic [2:0] mode;
  logic [3:0] in_data, out_data;
  logic carry, zero, ser_out_msb, ser_out_lsb;
  int checks = 0, errors = 0;
  int mq = 0, mc = 0;
  bit checking = 0;
  universal_register #(.WIDTH(4), .RESET_VALUE(4'h0)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_data(in_data), .ser_in(ser_in),
    .out_data(out_data), .carry(carry), .zero(zero),
    .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      mq = 0; mc = 0;
    end else case (mode)
      MODE_LOAD: begin mq = int'(in_data); mc = 0; end
      MODE_SHL:  begin mc = mq / 8; mq = (mq * 2 + int'(ser_in)) % 16; end
      MODE_SHR:  begin mc = mq % 2; mq = mq / 2 + 8 * int'(ser_in); end
      MODE_ROL:  begin mc = mq / 8; mq = (mq * 2 + mq / 8) % 16; end
      MODE_ROR:  begin mc = mq % 2; mq = mq / 2 + 8 * (mq % 2); end
      MODE_INC:  begin mc = (mq == 15) ? 1 : 0; mq = (mq + 1) % 16; end
      MODE_DEC:  begin mc = (mq == 0) ? 1 : 0; mq = (mq + 15) % 16; end
      default: ;
    endcase
  end
  always @(negedge clk) if (checking) begin
    chk("model_q", int'(out_data), mq);
    chk("model_carry", int'(carry), mc);
    chk("model_zero", int'(zero), (mq == 0) ? 1 : 0);
    chk("model_msb", int'(ser_out_msb), mq / 8);
    chk("model_lsb", int'(ser_out_lsb), mq % 2);
  end
  task automatic step(logic r, logic [2:0] m, logic [3:0] d, logic s);
    reset = r; mode = m; in_data = d; ser_in = s;
    @(negedge clk);
  endtask
  task automatic lit(string n, int q, int c);
    chk({n, "_q"}, int'(out_data), q);
    chk({n, "_carry"}, int'(carry), c);
    chk({n, "_zero"}, int'(zero), (q == 0) ? 1 : 0);
  endtask
  initial begin
    step(1, MODE_LOAD, 4'b0100, 0);
    step(1, MODE_LOAD, 4'b0100, 0);
    checking = 1;
    lit("reset", 0, 0);
    step(0, MODE_LOAD, 4'b0100, 0); lit("load_after_reset", 4, 0);
    step(0, MODE_LOAD, 4'b1010, 0); lit("load_1010", 10, 0);
    step(0, MODE_SHL, 4'b0000, 1);  lit("shl", 5, 1);
    step(0, MODE_SHR, 4'b1111, 0);  lit("shr", 2, 1);
    step(0, MODE_SHR, 4'b0000, 1);  lit("shr_ser1", 9, 0);
    step(0, MODE_LOAD, 4'b1001, 0); lit("load_1001", 9, 0);
    step(0, MODE_ROL, 4'b0110, 0);  lit("rol", 3, 1);
    step(0, MODE_ROR, 4'b0110, 1);  lit("ror", 9, 1);
    step(0, MODE_ROR, 4'b0000, 0);  lit("ror2", 12, 1);
    step(0, MODE_ROL, 4'b0000, 1);  lit("rol2", 9, 1);
    step(0, MODE_LOAD, 4'b1111, 0); lit("load_1111", 15, 0);
    step(0, MODE_INC, 4'b0000, 0);  lit("inc_wrap", 0, 1);
    step(0, MODE_INC, 4'b0000, 0);  lit("inc", 1, 0);
    step(0, MODE_DEC, 4'b1010, 1);  lit("dec_to_zero", 0, 0);
    step(0, MODE_LOAD, 4'b0000, 0); lit("load_0000", 0, 0);
    step(0, MODE_DEC, 4'b0000, 0);  lit("dec_borrow", 15, 1);
    step(0, MODE_LOAD, 4'b0011, 0); lit("load_0011", 3, 0);
    step(0, MODE_INC, 4'b0000, 0);  lit("inc_seq1", 4, 0);
    step(1, MODE_INC, 4'b0000, 0);  lit("inc_seq_reset", 0, 0);
    step(0, MODE_INC, 4'b0000, 0);  lit("inc_seq3", 1, 0);
    step(0, MODE_LOAD, 4'b0110, 0); lit("load_0110", 6, 0);
    step(0, MODE_SHL, 4'b0000, 1);  lit("shl_0110", 13, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, MODE_HOLD, 4'($urandom_range(15)), 1'($urandom_range(1)));
      lit("hold", 13, 0);
    end
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(15) == 0), 3'($urandom_range(7)), 4'($urandom_range(15)), 1'($urandom_range(1)));
    checking = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised successor to the plain 4-bit load register: a WIDTH-bit register with eight operating modes.
- Modes: hold, parallel load, shift, rotate, increment and decrement.
- Serial in/out, registered carry and a zero flag.
- Used as a general datapath storage/shift/count element wherever a bare register used to sit.

Parameters:
- WIDTH, 4, data width in bits (>=2).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into out_data on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- mode  input  3  operation select, sampled each rising edge
- in_data  input  WIDTH  parallel load data
- ser_in  input  1  serial input bit for shift modes
- out_data  output  WIDTH  registered register contents
- carry  output  1  registered carry/borrow/shifted-out bit
- zero  output  1  combinational, 1 when out_data == 0
- ser_out_msb  output  1  combinational, out_data[WIDTH-1]
- ser_out_lsb  output  1  combinational, out_data[0]

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state changes happen on the rising edge of clk only.
- Reset has priority over any mode: out_data <= RESET_VALUE, carry <= 0. zero then reflects RESET_VALUE.
- Latency is 1 cycle: the result of the mode sampled at edge N is visible on out_data/carry after edge N.
- Modes (Q = out_data, W = WIDTH):
  - 000 HOLD: Q unchanged, carry unchanged.
  - 001 LOAD: Q <= in_data, carry <= 0.
  - 010 SHL: Q <= {Q[W-2:0], ser_in}, carry <= Q[W-1].
  - 011 SHR: Q <= {ser_in, Q[W-1:1]}, carry <= Q[0].
  - 100 ROL: Q <= {Q[W-2:0], Q[W-1]}, carry <= Q[W-1]; ser_in ignored.
  - 101 ROR: Q <= {Q[0], Q[W-1:1]}, carry <= Q[0]; ser_in ignored.
  - 110 INC: Q <= Q+1 modulo 2^W; carry <= 1 only when Q was all-ones (wrap to 0), else 0.
  - 111 DEC: Q <= Q-1 modulo 2^W; carry <= 1 only when Q was 0 (borrow, wrap to all-ones), else 0.
- Arithmetic is unsigned, computed W+1 bits wide. The MSB of the W+1-bit result is carry/borrow.
- No X propagation from unused inputs: in_data is ignored outside LOAD; ser_in is ignored outside SHL/SHR.
- Reset asserted mid-sequence (e.g. during a run of INC) overrides the mode on that edge. The sequence resumes from RESET_VALUE once reset drops.
- mode changes take effect on the next edge with no pipeline bubble.
- zero, ser_out_msb and ser_out_lsb are pure decodes of the registered out_data, so they are glitch-free relative to the clock.

Decomposition:
- Shared package file register_pkg holds the 3-bit mode encodings MODE_HOLD..MODE_DEC as localparams/constants, for use by RTL and testbench.
- No sub-module. The next-state case statement and the flag decode live in universal_register.

Test Plan (WIDTH=4, RESET_VALUE=4'h0):
- reset=1, mode=LOAD, in_data=4'b0100 for 2 edges -> out_data=0000, carry=0, zero=1. Drop reset, one edge -> out_data=0100, zero=0.
- LOAD 1010; then SHL with ser_in=1 -> out_data=0101, carry=1; then SHR with ser_in=0 -> out_data=0010, carry=1.
- LOAD 1001; ROL -> 0011, carry=1; ROR -> 1001, carry=1. ser_in toggling has no effect.
- LOAD 1111; INC -> 0000, carry=1, zero=1; INC -> 0001, carry=0; LOAD 0000; DEC -> 1111, carry=1.
- LOAD 0011 then INC for 3 edges, with reset=1 on the 2nd edge -> sequence 0100, 0000 (carry=0), 0001.
- LOAD 0110, SHL ser_in=1 (carry=0), then HOLD for 5 edges with in_data/ser_in randomised -> out_data stays 1101, carry stays 0.
